// File: rtl/decoder_index_sequencer.sv
// decoder_index_sequencer
// Select generator for the 3-to-8 decoder. Steps a registered 3-bit index
// from 0 to LAST and holds each value for DWELL cycles. It either wraps
// forever (continuous) or finishes after one pass (one-shot). A scan can be
// aborted with stop, and the index can be redirected with load.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a scan from IDLE (one_shot sampled with it)
//   stop              abort a running scan
//   one_shot          1 = single pass, 0 = continuous
//   load, load_idx    jump request and target (ignored if load_idx > LAST)
//   sel, sel_valid    index to decoder, qualified while a scan drives it
//   busy              scan in progress
//   wrap              1-cycle pulse as a continuous scan returns to 0
//   done              1-cycle pulse as a one-shot scan completes
module decoder_index_sequencer #(
  parameter int DWELL = 4,
  parameter int LAST  = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       one_shot,
  input  logic       load,
  input  logic [2:0] load_idx,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       busy,
  output logic       wrap,
  output logic       done
);

  localparam int CW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [2:0]    LAST_IDX = 3'(LAST);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_ok;

  // Out-of-range jump targets are dropped so sel never exceeds LAST.
  assign load_ok = load && (load_idx <= LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = S_RUN;
          mode_d  = one_shot;
          cnt_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          sel_d   = load_ok ? load_idx : 3'd0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (load_ok) begin
          sel_d = load_idx;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sel_q < LAST_IDX) begin
            sel_d = sel_q + 3'd1;
          end else if (!mode_q) begin
            sel_d  = 3'd0;
            wrap_d = 1'b1;
          end else begin
            // One-shot finish: sel stays at LAST for the decoder to see.
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // done is already showing; start here is deliberately dropped.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sel       = sel_q;
  assign sel_valid = valid_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule

// File: tb/tb_decoder_index_sequencer.sv
module tb_decoder_index_sequencer;
  localparam int DWELL = 3;
  localparam int LAST  = 5;

  logic       clk = 1'b0;
  logic       rst, start, stop, one_shot, load;
  logic [2:0] load_idx;
  logic [2:0] sel;
  logic       sel_valid, busy, wrap, done;

  int n_chk = 0;
  int n_err = 0;

  // Reference: what the decoder should see, in terms of "which index, how
  // long it has been shown, and whether a scan is live".
  bit m_active, m_mode, m_wrap, m_done, m_fin;
  int m_idx, m_age;

  always #5 clk = ~clk;

  decoder_index_sequencer #(.DWELL(DWELL), .LAST(LAST)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
    .load(load), .load_idx(load_idx), .sel(sel), .sel_valid(sel_valid),
    .busy(busy), .wrap(wrap), .done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    m_wrap = 0;
    m_done = 0;
    if (rst) begin
      m_active = 0; m_mode = 0; m_fin = 0; m_idx = 0; m_age = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_mode   = one_shot;
        m_age    = 0;
        m_idx    = (load && int'(load_idx) <= LAST) ? int'(load_idx) : 0;
      end
    end else if (stop) begin
      m_active = 0;
    end else if (load && int'(load_idx) <= LAST) begin
      m_idx = int'(load_idx);
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == DWELL) begin
        m_age = 0;
        if (m_idx < LAST) m_idx++;
        else if (!m_mode) begin m_idx = 0; m_wrap = 1; end
        else begin m_active = 0; m_done = 1; m_fin = 1; end
      end
    end
  endfunction

  // Inputs are applied after a negedge; one rising edge; model and DUT
  // compared 1 ns later.
  task automatic cyc(input bit r, input bit s, input bit sp, input bit os,
                     input bit ld, input int li);
    rst = r; start = s; stop = sp; one_shot = os; load = ld; load_idx = 3'(li);
    @(posedge clk);
    model_step();
    #1;
    chk("sel", int'(sel), m_idx);
    chk("sel_valid", int'(sel_valid), int'(m_active));
    chk("busy", int'(busy), int'(m_active));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("done", int'(done), int'(m_done));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int cnt;
    @(negedge clk);
    // Reset, then quiet idle.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(10);
    chk("idle_sel", int'(sel), 0);

    // Continuous scan: first wrap after (LAST+1)*DWELL cycles.
    cyc(0, 1, 0, 0, 0, 0);
    cnt = 0;
    while (wrap !== 1'b1 && cnt < 60) begin idle(1); cnt++; end
    chk("wrap_period", cnt, (LAST + 1) * DWELL);
    chk("wrap_sel", int'(sel), 0);

    // Load in range, then out of range (7 > LAST is ignored).
    cnt = 0;
    while (sel !== 3'd2 && cnt < 40) begin idle(1); cnt++; end
    cyc(0, 0, 0, 0, 1, 4);
    chk("load_sel", int'(sel), 4);
    idle(DWELL - 1);
    chk("load_hold", int'(sel), 4);
    cyc(0, 0, 0, 0, 1, 7);
    chk("load_oob", int'(sel), 5);

    // Stop while sel=3, sel holds; restart begins at 0.
    cnt = 0;
    while (sel !== 3'd3 && cnt < 40) begin idle(1); cnt++; end
    cyc(0, 0, 1, 0, 1, 1);
    chk("stop_sel", int'(sel), 3);
    chk("stop_busy", int'(busy), 0);
    idle(3);
    cyc(0, 1, 0, 0, 0, 0);
    chk("restart_sel", int'(sel), 0);
    cyc(0, 0, 1, 0, 0, 0);

    // One-shot from a start+load at 3; done pulse, start during DONE dropped.
    cyc(0, 1, 0, 1, 1, 3);
    chk("startload_sel", int'(sel), 3);
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin idle(1); cnt++; end
    chk("oneshot_len", cnt, (LAST - 3 + 1) * DWELL);
    chk("done_sel", int'(sel), LAST);
    cyc(0, 1, 0, 0, 0, 0);
    chk("done_start_ign", int'(busy), 0);
    idle(2);

    // Reset mid-run.
    cyc(0, 1, 0, 0, 0, 0);
    idle(4);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_run_valid", int'(sel_valid), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 14) == 0),
          int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
